pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central hazard and stall controller for the 5-stage MIPS pipeline. It detects load-use and branch data hazards, generates the D-stage (branch-compare) and E-stage forwarding selects, and issues stall/flush controls to the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also sequences a global pipeline freeze while data memory is not ready, with a timeout that escalates to a sticky error state. Performance counters are optional and compiled in with a macro.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive memory-wait cycles before the ERROR state is entered; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- RsD, RtD  in  5 each  source register numbers in the D stage.
- RsE, RtE  in  5 each  source register numbers in the E stage.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register numbers in E, M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables per stage.
- MemtoRegE, MemtoRegM  in  1 each  load-in-stage flags.
- BranchD  in  1  a branch is being decoded in D.
- MemReqM  in  1  a load or store occupies the M stage.
- MemReadyM  in  1  data memory completes the M-stage access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushE  out  1  clear ID/EX (drives the ID/EX `clr`).
- FlushW  out  1  insert a bubble into MEM/WB.
- ForwardAD, ForwardBD  out  1 each  select ALUOutM for the branch comparator inputs.
- ForwardAE, ForwardBE  out  2 each  E-stage ALU operand select: 00 = register file, 01 = ResultW, 10 = ALUOutM.
- MemErr  out  1  sticky memory-timeout error flag.
- StallCnt, FlushCnt, MemWaitCnt  out  32 each  performance counters (see Configuration).

## Operation
- States: RUN, MEMWAIT, ERROR. The reset state is RUN.
- Definitions:
  - lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
  - brstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
  - memstall = MemReqM & ~MemReadyM.
- Forwarding, computed in every state except ERROR:
  - ForwardAE = 10 if RsE≠0 & RegWriteM & WriteRegM==RsE.
  - Else ForwardAE = 01 if RsE≠0 & RegWriteW & WriteRegW==RsE.
  - Else ForwardAE = 00.
  - ForwardBE follows the same rule with RtE; M has priority over W.
  - ForwardAD = RsD≠0 & RegWriteM & WriteRegM==RsD; ForwardBD is the same with RtD.
- RUN or MEMWAIT with memstall=1:
  - StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushE = 0.
  - memstall overrides lwstall and brstall, so no bubble is lost.
- RUN or MEMWAIT with memstall=0:
  - StallF = StallD = FlushE = lwstall | brstall.
  - StallE = StallM = FlushW = 0.
- ERROR:
  - All stalls = 1, FlushW = 1, FlushE = 0.
  - All forward selects = 0, MemErr = 1.
- Transitions:
  - RUN→MEMWAIT when memstall.
  - MEMWAIT→RUN when ~memstall.
  - MEMWAIT→ERROR when memstall and wait_cnt == MEM_TIMEOUT-1.
  - ERROR is exited only by clr.
- wait_cnt (width $clog2(MEM_TIMEOUT+1)):
  - Increments on every memstall cycle.
  - Clears on any cycle with memstall=0.
  - Does not wrap.
- Register 0 never matches for forwarding. Register 0 does participate in the lwstall/brstall compares; this is conservative and harmless.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the current state. Zero latency: a hazard stalls the pipeline in the same cycle it is present.
- Values while clr=1: state = RUN, wait_cnt = 0, MemErr = 0, all counters = 0. The other outputs follow the RUN decode of the current inputs.
- Load-use hazard: exactly 1 stall cycle.
- Branch hazard on an E-stage ALU producer: 1 cycle. On an M-stage load: 1 cycle. On an E-stage load: 2 cycles (lwstall, then brstall).
- Memory wait: stall for N cycles while MemReadyM=0.
  - If N < MEM_TIMEOUT, the pipeline resumes in the cycle MemReadyM=1.
  - After exactly MEM_TIMEOUT consecutive memstall cycles, ERROR is entered on the next edge.
- MemReadyM rising in the same cycle wait_cnt == MEM_TIMEOUT-1 gives memstall=0, so the next state is RUN, not ERROR.
- clr asserted mid-wait returns to RUN immediately; it is asynchronous.

## Configuration
- HAZARD_PERF_CNT_EN defined: StallCnt counts cycles with StallD=1, FlushCnt counts cycles with FlushE=1, MemWaitCnt counts memstall cycles. All three are 32-bit, saturate at 32'hFFFFFFFF, and are cleared by clr.
- HAZARD_PERF_CNT_EN undefined: the counter logic is removed, the three ports remain, and they are tied to 0.

## Structure
- Shared package mips_pipe_pkg holds:
  - The state enum (RUN, MEMWAIT, ERROR).
  - The forward-select constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- Sub-module fwd_sel is combinational: inputs src, WriteRegM, RegWriteM, WriteRegW, RegWriteW; output is the 2-bit select. It is instantiated for both A and B E-stage operands.

## Test plan
- Forwarding: RsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5 → ForwardAE=10. Same with RsE=0 → ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for one cycle. Next cycle (E bubble) → all 0.
- Branch hazard: BranchD=1, RegWriteE=1, WriteRegE=3, RsD=3 → one stall. Then WriteRegM=3 with RegWriteM=1 → ForwardAD=1 and no stall.
- Memory wait: MemReqM=1, MemReadyM=0 for 4 cycles, then 1 (MEM_TIMEOUT=15) → all stalls and FlushW=1 for 4 cycles, RUN on cycle 5, MemErr=0.
- Timeout: MemReadyM held 0 → ERROR after 15 cycles, MemErr=1, stays set when MemReadyM later goes 1. Pulse clr → MemErr=0, state RUN.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls plus a 4-cycle memory wait → StallCnt=7, FlushCnt=3, MemWaitCnt=4.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller:
// controller state encoding, forward-select codes and the forwarding match helper.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ERROR   = 2'b10
  } hazState_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register 0 is hard-wired to zero, so it never becomes a forwarding source.
  function automatic logic srcHit(input logic [4:0] src,
                                  input logic [4:0] dst,
                                  input logic       we);
    return we && (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipeline_hazard_ctrl_if;

  logic [4:0]  RsD, RtD, RsE, RtE;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic        MemtoRegE, MemtoRegM;
  logic        BranchD, MemReqM, MemReadyM;

  logic        StallF, StallD, StallE, StallM;
  logic        FlushE, FlushW;
  logic        ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MemErr;
  logic [31:0] StallCnt, FlushCnt, MemWaitCnt;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushE, FlushW,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE, MemErr,
           StallCnt, FlushCnt, MemWaitCnt
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushE, FlushW,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE, MemErr,
           StallCnt, FlushCnt, MemWaitCnt
  );

endinterface

// File: rtl/fwd_sel.sv
// E-stage operand forward select: M-stage result wins over W-stage result,
// otherwise the register file value is used.
module fwd_sel
  import mips_pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] WriteRegM,
  input  logic       RegWriteM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteW,
  output logic [1:0] fwd
);

  // Priority select, youngest producer first.
  always_comb begin
    fwd = FWD_RF;
    if (srcHit(src, WriteRegM, RegWriteM)) begin
      fwd = FWD_MEM;
    end else if (srcHit(src, WriteRegW, RegWriteW)) begin
      fwd = FWD_WB;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/forward controller for the 5-stage MIPS pipeline with a
// memory-wait timeout. Optional performance counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
)(
  input  logic                  clk,
  input  logic                  clr,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};

  hazState_t         state, stateNext;
  logic [WAIT_W-1:0] waitCnt, waitNext;

  logic       lwStall, brStall, memStall, atTimeout;
  logic [1:0] fwdA, fwdB;
  logic       stallF, stallD, stallE, stallM, flushE, flushW;
  logic       fwdAD, fwdBD, memErr;
  logic [1:0] fwdAE, fwdBE;

  assign lwStall  = hz.MemtoRegE & ((hz.RtE == hz.RsD) | (hz.RtE == hz.RtD));
  assign brStall  = hz.BranchD &
                    ((hz.RegWriteE & ((hz.WriteRegE == hz.RsD) | (hz.WriteRegE == hz.RtD))) |
                     (hz.MemtoRegM & ((hz.WriteRegM == hz.RsD) | (hz.WriteRegM == hz.RtD))));
  assign memStall  = hz.MemReqM & ~hz.MemReadyM;
  assign atTimeout = (waitCnt == WAIT_LAST);

  fwd_sel uFwdA (
    .src       (hz.RsE),
    .WriteRegM (hz.WriteRegM),
    .RegWriteM (hz.RegWriteM),
    .WriteRegW (hz.WriteRegW),
    .RegWriteW (hz.RegWriteW),
    .fwd       (fwdA)
  );

  fwd_sel uFwdB (
    .src       (hz.RtE),
    .WriteRegM (hz.WriteRegM),
    .RegWriteM (hz.RegWriteM),
    .WriteRegW (hz.WriteRegW),
    .RegWriteW (hz.RegWriteW),
    .fwd       (fwdB)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Consecutive memory-wait counter; saturates rather than wrapping.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      waitCnt <= '0;
    end else begin
      waitCnt <= waitNext;
    end
  end

  // Next wait count.
  always_comb begin
    waitNext = waitCnt;
    if (!memStall) begin
      waitNext = '0;
    end else if (waitCnt != WAIT_MAX) begin
      waitNext = waitCnt + WAIT_W'(1);
    end else begin
      waitNext = waitCnt;
    end
  end

  // Next state and stall/flush/forward decode. An unencoded state is treated
  // like ERROR so the pipeline freezes instead of running on corrupt control.
  always_comb begin
    stateNext = state;
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    fwdAE  = FWD_RF;
    fwdBE  = FWD_RF;
    fwdAD  = 1'b0;
    fwdBD  = 1'b0;
    memErr = 1'b0;
    case (state)
      RUN, MEMWAIT: begin
        fwdAE = fwdA;
        fwdBE = fwdB;
        fwdAD = srcHit(hz.RsD, hz.WriteRegM, hz.RegWriteM);
        fwdBD = srcHit(hz.RtD, hz.WriteRegM, hz.RegWriteM);
        if (memStall) begin
          // Freeze everything up to M; the held D/E hazard is re-evaluated later.
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
          flushW = 1'b1;
          stateNext = atTimeout ? ERROR : MEMWAIT;
        end else begin
          stallF = lwStall | brStall;
          stallD = lwStall | brStall;
          flushE = lwStall | brStall;
          stateNext = RUN;
        end
      end
      ERROR: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
        memErr = 1'b1;
        stateNext = ERROR;
      end
      default: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
        memErr = 1'b1;
        stateNext = ERROR;
      end
    endcase
  end

  assign hz.StallF    = stallF;
  assign hz.StallD    = stallD;
  assign hz.StallE    = stallE;
  assign hz.StallM    = stallM;
  assign hz.FlushE    = flushE;
  assign hz.FlushW    = flushW;
  assign hz.ForwardAE = fwdAE;
  assign hz.ForwardBE = fwdBE;
  assign hz.ForwardAD = fwdAD;
  assign hz.ForwardBD = fwdBD;
  assign hz.MemErr    = memErr;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt, memWaitCnt;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stallCnt   <= 32'd0;
      flushCnt   <= 32'd0;
      memWaitCnt <= 32'd0;
    end else begin
      if (stallD && (stallCnt != 32'hFFFF_FFFF)) begin
        stallCnt <= stallCnt + 32'd1;
      end else begin
        stallCnt <= stallCnt;
      end
      if (flushE && (flushCnt != 32'hFFFF_FFFF)) begin
        flushCnt <= flushCnt + 32'd1;
      end else begin
        flushCnt <= flushCnt;
      end
      if (memStall && (memWaitCnt != 32'hFFFF_FFFF)) begin
        memWaitCnt <= memWaitCnt + 32'd1;
      end else begin
        memWaitCnt <= memWaitCnt;
      end
    end
  end

  assign hz.StallCnt   = stallCnt;
  assign hz.FlushCnt   = flushCnt;
  assign hz.MemWaitCnt = memWaitCnt;
`else
  assign hz.StallCnt   = 32'd0;
  assign hz.FlushCnt   = 32'd0;
  assign hz.MemWaitCnt = 32'd0;
`endif

endmodule
